// File: rtl/ref_level_est.sv
// Block-averaged |x| estimator that produces the 4-ASK slicer threshold.
// Each block of 2^LOG2_N symbols yields a truncating mean of |in_phs_sig|.
module ref_level_est #(
    parameter int                 LOG2_N   = 10,
    parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic signed [17:0] in_phs_sig,
    input  logic               freeze,
    output logic signed [17:0] ref_level,
    output logic               ref_valid,
    output logic               block_done
);

    localparam int ACC_W = 17 + LOG2_N;

    typedef enum logic {
        ACQ,
        TRACK
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic signed [17:0]  ref_q, ref_d;
    logic                done_q, done_d;

    logic [16:0]         mag;
    logic [17:0]         negIn;
    logic [ACC_W-1:0]    sum;
    logic                blockEnd;
    logic                loadRef;

    // -131072 has no positive 18-bit counterpart, so it saturates to 131071.
    assign negIn = -in_phs_sig;

    always_comb begin
        if (in_phs_sig == -18'sd131072) begin
            mag = 17'h1FFFF;
        end else if (in_phs_sig[17]) begin
            mag = negIn[16:0];
        end else begin
            mag = in_phs_sig[16:0];
        end
    end

    assign sum      = acc_q + ACC_W'(mag);
    assign blockEnd = clk_en && (cnt_q == '1);
    assign loadRef  = blockEnd && !freeze;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ref_d  = ref_q;
        done_d = blockEnd;
        if (clk_en) begin
            cnt_d = cnt_q + LOG2_N'(1);
            acc_d = blockEnd ? '0 : sum;
        end
        // The completing sample is folded in, so the mean is ready on the same edge.
        if (loadRef) begin
            ref_d = {1'b0, sum[LOG2_N +: 17]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACQ;
            acc_q   <= '0;
            cnt_q   <= '0;
            ref_q   <= REF_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACQ:     if (loadRef) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = ACQ;
        endcase
    end

    always_comb begin
        ref_valid = (state_q == TRACK);
    end

    assign ref_level  = ref_q;
    assign block_done = done_q;

endmodule

// File: tb/tb_ref_level_est.sv
// Directed bench for ref_level_est with LOG2_N=2 (4-sample blocks).
// Table-driven vectors plus a hand-written gap/reset sequence.
module tb_ref_level_est;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic signed [17:0] in_phs_sig;
    logic               freeze;
    logic signed [17:0] ref_level;
    logic               ref_valid;
    logic               block_done;

    int testsRun    = 0;
    int testsFailed = 0;

    localparam int INIT = 32768;

    always #5 clk = ~clk;

    ref_level_est #(
        .LOG2_N  (2),
        .REF_INIT(18'sd32768)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .in_phs_sig(in_phs_sig),
        .freeze    (freeze),
        .ref_level (ref_level),
        .ref_valid (ref_valid),
        .block_done(block_done)
    );

    typedef struct {
        logic  rst;
        logic  en;
        int    din;
        logic  frz;
        int    expRef;
        logic  expValid;
        logic  expDone;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rst, input logic en, input int din, input logic frz,
                          input int expRef, input logic expValid, input logic expDone,
                          input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.din = din; v.frz = frz;
        v.expRef = expRef; v.expValid = expValid; v.expDone = expDone; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs and step just past the rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input int din, input logic frz);
        reset      = rst;
        clk_en     = en;
        in_phs_sig = 18'(din);
        freeze     = frz;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int expRef, input logic expValid,
                               input logic expDone);
        testsRun++;
        if (ref_level !== 18'(expRef)) begin
            testsFailed++;
            $display("[TB] FAIL %s ref_level: got %0d expected %0d", name, ref_level, expRef);
        end
        testsRun++;
        if (ref_valid !== expValid) begin
            testsFailed++;
            $display("[TB] FAIL %s ref_valid: got %0b expected %0b", name, ref_valid, expValid);
        end
        testsRun++;
        if (block_done !== expDone) begin
            testsFailed++;
            $display("[TB] FAIL %s block_done: got %0b expected %0b", name, block_done, expDone);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; clk_en = 1'b0; in_phs_sig = '0; freeze = 1'b0;

        addVec(1, 1, 999, 0, INIT, 0, 0, "reset");
        // Constant +40000 block: first estimate.
        addVec(0, 1, 40000, 0, INIT, 0, 0, "c40k_s0");
        addVec(0, 1, 40000, 0, INIT, 0, 0, "c40k_s1");
        addVec(0, 1, 40000, 0, INIT, 0, 0, "c40k_s2");
        addVec(0, 1, 40000, 0, 40000, 1, 1, "c40k_s3");
        addVec(0, 0, 0, 0, 40000, 1, 0, "c40k_idle");
        // Four-level symbols, then truncation.
        addVec(0, 1, 16384, 0, 40000, 1, 0, "ask_s0");
        addVec(0, 1, -49152, 0, 40000, 1, 0, "ask_s1");
        addVec(0, 1, 49152, 0, 40000, 1, 0, "ask_s2");
        addVec(0, 1, -16384, 0, 32768, 1, 1, "ask_s3");
        addVec(0, 1, 1, 0, 32768, 1, 0, "trunc_s0");
        addVec(0, 1, 1, 0, 32768, 1, 0, "trunc_s1");
        addVec(0, 1, 1, 0, 32768, 1, 0, "trunc_s2");
        addVec(0, 1, 2, 0, 1, 1, 1, "trunc_s3");
        // Most-negative input saturates.
        addVec(0, 1, -131072, 0, 1, 1, 0, "sat_s0");
        addVec(0, 1, -131072, 0, 1, 1, 0, "sat_s1");
        addVec(0, 1, -131072, 0, 1, 1, 0, "sat_s2");
        addVec(0, 1, -131072, 0, 131071, 1, 1, "sat_s3");
        // Samples 100,200,300,404 with idle gaps carrying garbage: mean 251.
        addVec(0, 0, -77777, 1, 131071, 1, 0, "gap_g0");
        addVec(0, 1, 100, 0, 131071, 1, 0, "gap_s0");
        addVec(0, 0, 123456, 0, 131071, 1, 0, "gap_g1");
        addVec(0, 0, -131072, 1, 131071, 1, 0, "gap_g2");
        addVec(0, 1, -200, 0, 131071, 1, 0, "gap_s1");
        addVec(0, 1, 300, 0, 131071, 1, 0, "gap_s2");
        addVec(0, 0, 99999, 0, 131071, 1, 0, "gap_g3");
        addVec(0, 1, 404, 0, 251, 1, 1, "gap_s3");
        // Freeze sampled only at completion.
        addVec(1, 0, 0, 0, INIT, 0, 0, "frz_reset");
        addVec(0, 1, 1000, 0, INIT, 0, 0, "frz_a0");
        addVec(0, 1, 1000, 1, INIT, 0, 0, "frz_a1");
        addVec(0, 1, 1000, 0, INIT, 0, 0, "frz_a2");
        addVec(0, 1, 1000, 1, INIT, 0, 1, "frz_a3");
        addVec(0, 1, 8000, 1, INIT, 0, 0, "frz_b0");
        addVec(0, 1, 8000, 1, INIT, 0, 0, "frz_b1");
        addVec(0, 1, -8000, 1, INIT, 0, 0, "frz_b2");
        addVec(0, 1, 8000, 0, 8000, 1, 1, "frz_b3");
        // Reset mid-block discards the partial sum.
        addVec(0, 1, 100000, 0, 8000, 1, 0, "mid_p0");
        addVec(0, 1, 100000, 0, 8000, 1, 0, "mid_p1");
        addVec(1, 1, 100000, 0, INIT, 0, 0, "mid_reset");
        addVec(0, 1, 20000, 0, INIT, 0, 0, "mid_s0");
        addVec(0, 1, 20000, 0, INIT, 0, 0, "mid_s1");
        addVec(0, 1, 20000, 0, INIT, 0, 0, "mid_s2");
        addVec(0, 1, 20000, 0, 20000, 1, 1, "mid_s3");
        addVec(0, 0, 0, 0, 20000, 1, 0, "mid_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].frz);
            checkOutput(vecs[i].name, vecs[i].expRef, vecs[i].expValid, vecs[i].expDone);
        end

        // Hand-written: partial block, reset with clk_en low, then a fresh block
        // whose completion is followed by an immediate next-block sample.
        applyStimulus(0, 1, 70000, 0);
        checkOutput("seq_pre0", 20000, 1, 0);
        applyStimulus(1, 0, 70000, 0);
        checkOutput("seq_reset_noen", INIT, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, -5000, 0);
            checkOutput("seq_s012", INIT, 0, 0);
            applyStimulus(0, 0, 131071, 1);
            checkOutput("seq_gap", INIT, 0, 0);
        end
        applyStimulus(0, 1, 5001, 0);
        checkOutput("seq_s3", 5000, 1, 1);
        applyStimulus(0, 1, 60000, 0);
        checkOutput("seq_next0", 5000, 1, 0);
        applyStimulus(0, 1, 60000, 0);
        checkOutput("seq_next1", 5000, 1, 0);
        applyStimulus(0, 1, 60000, 0);
        checkOutput("seq_next2", 5000, 1, 0);
        applyStimulus(0, 1, 60003, 0);
        checkOutput("seq_next3", 60000, 1, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ref_level_est.md
REF_LEVEL_EST -- requirements
Module: ref_level_est

Interface
- REQ-001: Parameter LOG2_N, default 10: log2 of the block length; each estimate averages 2^LOG2_N symbols; legal range 1..16.
- REQ-002: Parameter REF_INIT, default 18'sd32768: the ref_level value held from reset until the first estimate.
- REQ-003: clk  input  1  system clock; all state updates on its rising edge.
- REQ-004: reset  input  1  reset, synchronous and active-high.
- REQ-005: clk_en  input  1  symbol strobe; one in_phs_sig sample is consumed per cycle with clk_en=1.
- REQ-006: in_phs_sig  input  18 signed (1s17)  in-phase matched-filter output at symbol centre.
- REQ-007: freeze  input  1  when high, completed blocks do not update ref_level.
- REQ-008: ref_level  output  18 signed (1s17)  decision threshold for the 4-ASK slicer; always >= 0.
- REQ-009: ref_valid  output  1  high once the first unfrozen estimate has been loaded.
- REQ-010: block_done  output  1  one-clk pulse on the edge that completes each block.

Function
- REQ-011: The block SHALL compute mag = |in_phs_sig|, saturating -131072 to 131071 (17-bit unsigned result).
- REQ-012: On each clk_en=1 edge, the block SHALL add mag to an unsigned accumulator of width 17+LOG2_N that never wraps, and SHALL increment a LOG2_N-bit sample counter.
- REQ-013: Edges with clk_en=0 SHALL leave all state unchanged; block_done is 0 on those edges.
- REQ-014: A block SHALL complete on the clk_en edge at which the counter equals 2^LOG2_N-1; that edge's sample is included.
- REQ-015: On block completion, the counter SHALL wrap to 0 and the accumulator SHALL clear to 0; the next sample starts a new block with no gap and no overlap.
- REQ-016: On block completion with freeze=0, the block SHALL load ref_level with (acc + mag) >> LOG2_N (truncating mean of |x|, equal to 2a for uniform levels ±a, ±3a) on the same edge, giving 0 cycles of added latency.
- REQ-017: On block completion with freeze=1, ref_level and ref_valid SHALL hold; accumulation and counting continue, and block_done still pulses.
- REQ-018: The block SHALL implement a state machine with states:
  - ACQ: from reset; ref_valid=0.
  - TRACK: ref_valid=1.
- REQ-019: The state machine SHALL make ACQ->TRACK on the first block completion with freeze=0; TRACK SHALL be left only by reset.
- REQ-020: freeze SHALL be sampled only on the completion edge; toggling freeze mid-block SHALL have no effect.
- REQ-021: block_done SHALL be registered, high for exactly the cycle following the completion edge.

Reset
- REQ-022: With reset=1 at an edge, the block SHALL set ref_level=REF_INIT, ref_valid=0, block_done=0, accumulator=0, counter=0 and state=ACQ, regardless of clk_en.
- REQ-023: Reset mid-block SHALL discard the partial sum; the first post-reset clk_en sample SHALL be sample 0 of a new block.

Verification (bench uses LOG2_N=2)
- REQ-024: Hold in_phs_sig=+40000 and pulse clk_en 4 times -> after the 4th edge ref_level=40000, ref_valid=1, block_done high for 1 cycle; ref_level=REF_INIT before that edge.
- REQ-025: Apply samples 16384, -49152, 49152, -16384 -> ref_level=32768; then apply 1, 1, 1, 2 -> ref_level=1 (truncation).
- REQ-026: Apply -131072 for 4 samples -> ref_level=131071 with no sign flip.
- REQ-027: Apply 4 samples with random clk_en=0 gaps while in_phs_sig carries garbage during the gaps -> result identical to the gapless case.
- REQ-028: Assert freeze=1 at the first completion -> ref_valid stays 0 and ref_level stays REF_INIT while block_done pulses; with freeze=0 at the second completion -> ref_level loads and ref_valid=1.
- REQ-029: Assert reset after 2 samples of 100000, then apply 4 samples of 20000 -> ref_level=20000, ref_valid rises only on the 4th post-reset sample.
